note_lane_scheduler: RTL and testbench
======================================

# note_lane_scheduler

Per-lane note scheduler for the Guitar Hero display path. Holds up to DEPTH active notes in an age-ordered circular buffer and advances every note's y position once per video frame. Retires notes that scroll off screen and, optionally, judges strums against the hit window. Exposes an indexed read port that the renderer feeds into the per-pixel note bounds checker as `note_y`.

## Interface
- DEPTH, 8: note slots per lane; power of two, at most 16
- Y_W, 9: y coordinate width (0..479 screen rows)
- SPEED, 2: rows added to every note per frame tick
- SCREEN_H, 480: a note whose y is at least this value is off screen
- HIT_LO, 400: hit window lower bound, inclusive
- HIT_HI, 440: hit window upper bound, inclusive

- clock  in  1  system clock; all state is updated on its rising edge
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  single-cycle pulse, once per frame (vsync)
- spawn_valid  in  1  request to spawn a new note at y=0
- spawn_ready  out  1  spawn is accepted on a cycle where spawn_valid and spawn_ready are both high
- strum  in  1  single-cycle pulse from the PS2 key decoder
- hit  out  1  single-cycle pulse: a strum hit the oldest note
- miss  out  1  single-cycle pulse: a note was retired unhit, or a strum did not hit
- rd_idx  in  log2(DEPTH)  slot to read, relative to the oldest note (0 = oldest)
- rd_y  out  Y_W  y position of slot rd_idx, registered
- rd_valid  out  1  rd_idx < count, registered
- count  out  log2(DEPTH)+1  number of active notes
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- **Storage:** y array[DEPTH], head and tail pointers that wrap modulo DEPTH, and count. Push writes y=0 at tail. Pop advances head.
- **FSM states:** IDLE, ADVANCE, RETIRE.
- **IDLE priority:** a pending or arriving frame tick goes first. It moves to ADVANCE with walk index i=0.
- **ADVANCE:** updates one slot per cycle, slot (head+i): y = min(y+SPEED, 2^Y_W-1). The sum is computed at Y_W+1 bits and saturates. The state moves to RETIRE after count slots. With count==0 it moves to RETIRE on the next cycle.
- **RETIRE:** if count>0 and y[head] >= SCREEN_H, pop the note and pulse miss. At most one retire per tick. Always returns to IDLE.
- **tick_pend:** a frame_tick that arrives while busy sets tick_pend. A second tick while tick_pend is set is dropped. IDLE consumes tick_pend.
- **spawn_ready:** (state==IDLE) && count<DEPTH && !frame_tick && !tick_pend.
- **Strum in IDLE:** evaluated that cycle against the head slot, before any same-cycle spawn.
- **strum_pend:** a strum while busy sets strum_pend, one deep; further strums are dropped. It is evaluated on the first IDLE cycle that has no tick pending.
- **Strum and spawn in the same cycle:** both are allowed. The pop and push use separate pointers. count changes by push minus pop.
- **Read port:** rd_y = y[(head+rd_idx) mod DEPTH]. rd_valid = (rd_idx < count).
- **Reset:** clears head, tail, count, tick_pend and strum_pend. The FSM goes to IDLE. Reset mid-ADVANCE abandons the walk. The y array is not cleared.

## Timing
- Reset values: spawn_ready=1, hit=0, miss=0, rd_y=0, rd_valid=0, count=0, busy=0.
- The read port has 1-cycle latency: rd_idx at cycle n produces rd_y/rd_valid at n+1. During ADVANCE it returns a mix of advanced and unadvanced values. The renderer reads only during active video, when no ADVANCE is in progress.
- A tick with count=N keeps busy high for N+2 cycles: 1 cycle for the IDLE→ADVANCE transition, N cycles of ADVANCE, then 1 cycle of RETIRE.
- hit and miss are registered and pulse the cycle after the judging or retiring cycle. hit and miss are never high together.
- count updates the cycle after a push or pop.

## Configuration
- **NOTE_LANE_HIT_EN defined:** strum judging is active. In-window means HIT_LO <= y[head] <= HIT_HI with count>0. An in-window strum pops the head and pulses hit. Any other strum pulses miss and pops nothing.
- **NOTE_LANE_HIT_EN not defined:** the strum input is ignored, strum_pend does not exist and hit is tied 0. miss pulses only on off-screen retirement.

## Test plan
- **Reset and fill:** reset, then 8 spawns on consecutive cycles → count=8 and spawn_ready low. A 9th spawn_valid is not accepted, and count stays 8.
- **Single-note tick:** 1 note, 1 frame_tick → busy high for 3 cycles, then rd_idx=0 returns rd_y=2 and rd_valid=1.
- **Off-screen retirement:** 1 note advanced to y=478, then a tick → y=480, retired in RETIRE, miss pulses once, count=0.
- **Hit-window strum (NOTE_LANE_HIT_EN):**
  - Note at y=420, strum in IDLE → hit 1 cycle later and count decrements.
  - Note at y=398, strum → miss and count unchanged.
- **Events while busy:** frame_tick and strum during ADVANCE with count=4 → each is serviced once after return to IDLE, tick first.
- **Spawn and strum together:** spawn_valid and strum in the same cycle with head y=410 → hit, head popped, new tail y=0, count unchanged.

Source files
------------

// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler
// Per-lane note store for the display path. Up to DEPTH notes are kept
// oldest-first in a circular buffer. Once per frame every note moves down by
// SPEED rows. A note that scrolls off screen is retired with a miss pulse.
// The renderer reads any note's y position through an indexed read port.
//
// Build option: define NOTE_LANE_HIT_EN to enable strum judging against the
// hit window. If it is not defined, strum is ignored and hit stays low.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   frame_tick   one pulse per frame; starts an advance pass
//   spawn_valid  request to add a note at y=0
//   spawn_ready  spawn is accepted when valid and ready are both high
//   strum        one pulse per strum from the key decoder
//   hit          registered pulse: a strum hit the oldest note
//   miss         registered pulse: a note was retired, or a strum missed
//   rd_idx       read slot, relative to the oldest note
//   rd_y         registered y value of slot rd_idx
//   rd_valid     registered rd_idx < count
//   count        number of active notes
//   busy         high while an advance/retire pass is running
//
// state   | meaning
// IDLE    | accepts spawns, judges strums, starts a pass on a frame tick
// ADVANCE | walks the live notes, one slot per cycle, adding SPEED
// RETIRE  | pops the oldest note if it is off screen, then returns to IDLE
module note_lane_scheduler #(
  parameter int DEPTH    = 8,
  parameter int Y_W      = 9,
  parameter int SPEED    = 2,
  parameter int SCREEN_H = 480,
  parameter int HIT_LO   = 400,
  parameter int HIT_HI   = 440,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             spawn_valid,
  output logic             spawn_ready,
  input  logic             strum,
  output logic             hit,
  output logic             miss,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ADVANCE, RETIRE} state_t;

  localparam logic [Y_W:0]   SCREEN_LIM = (Y_W+1)'(SCREEN_H);
  localparam logic [Y_W-1:0] HIT_LO_Y   = Y_W'(HIT_LO);
  localparam logic [Y_W-1:0] HIT_HI_Y   = Y_W'(HIT_HI);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] walk_q, walk_d;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             tick_pend_q, tick_pend_d;
  logic             hit_q, hit_d, miss_q, miss_d;
  logic [Y_W-1:0]   rd_y_q;
  logic             rd_valid_q;
  logic [Y_W-1:0]   y_mem [DEPTH];

  logic             push, pop, adv_we;
  logic [PTR_W-1:0] walk_slot;
  logic [Y_W:0]     adv_sum;
  logic [Y_W-1:0]   adv_y;
  logic [Y_W-1:0]   head_y;
  logic             in_window, off_screen;

  assign head_y     = y_mem[head_q];
  assign in_window  = (count_q != '0) && (head_y >= HIT_LO_Y) && (head_y <= HIT_HI_Y);
  assign off_screen = ({1'b0, head_y} >= SCREEN_LIM);

  // Saturate instead of wrapping so a stalled note never jumps back on screen.
  assign walk_slot = head_q + walk_q[PTR_W-1:0];
  assign adv_sum   = {1'b0, y_mem[walk_slot]} + (Y_W+1)'(SPEED);
  assign adv_y     = adv_sum[Y_W] ? '1 : adv_sum[Y_W-1:0];

  assign spawn_ready = (state_q == IDLE) && (count_q != FULL) && !frame_tick && !tick_pend_q;

`ifdef NOTE_LANE_HIT_EN
  logic strum_pend_q, strum_pend_d;
`else
  logic unused_strum;
  assign unused_strum = strum ^ in_window;
`endif

  always_comb begin
    state_d     = state_q;
    walk_d      = walk_q;
    tick_pend_d = tick_pend_q;
    push        = 1'b0;
    pop         = 1'b0;
    adv_we      = 1'b0;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
`ifdef NOTE_LANE_HIT_EN
    strum_pend_d = strum_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (frame_tick || tick_pend_q) begin
          state_d     = ADVANCE;
          walk_d      = '0;
          tick_pend_d = 1'b0;
`ifdef NOTE_LANE_HIT_EN
          // The tick wins this cycle; the strum waits for the pass to end.
          if (strum) strum_pend_d = 1'b1;
`endif
        end else begin
`ifdef NOTE_LANE_HIT_EN
          // Judged against the head before any same-cycle spawn lands.
          if (strum_pend_q || strum) begin
            strum_pend_d = 1'b0;
            if (in_window) begin
              pop   = 1'b1;
              hit_d = 1'b1;
            end else begin
              miss_d = 1'b1;
            end
          end
`endif
          push = spawn_valid && spawn_ready;
        end
      end
      ADVANCE: begin
        if (frame_tick) tick_pend_d = 1'b1;
`ifdef NOTE_LANE_HIT_EN
        if (strum) strum_pend_d = 1'b1;
`endif
        if (walk_q == count_q) begin
          state_d = RETIRE;
        end else begin
          adv_we = 1'b1;
          walk_d = walk_q + CNT_W'(1);
        end
      end
      RETIRE: begin
        if (frame_tick) tick_pend_d = 1'b1;
`ifdef NOTE_LANE_HIT_EN
        if (strum) strum_pend_d = 1'b1;
`endif
        if ((count_q != '0) && off_screen) begin
          pop    = 1'b1;
          miss_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      walk_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      tick_pend_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      rd_y_q      <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      walk_q      <= walk_d;
      tick_pend_q <= tick_pend_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      if (pop)  head_q <= head_q + PTR_W'(1);
      if (push) tail_q <= tail_q + PTR_W'(1);
      count_q     <= count_q + CNT_W'(push) - CNT_W'(pop);
      rd_y_q      <= y_mem[head_q + rd_idx];
      rd_valid_q  <= ({1'b0, rd_idx} < count_q);
    end
  end

`ifdef NOTE_LANE_HIT_EN
  always_ff @(posedge clock) begin
    if (reset) strum_pend_q <= 1'b0;
    else       strum_pend_q <= strum_pend_d;
  end
`endif

  // Note storage has no reset; only slots inside head..tail are ever observed.
  always_ff @(posedge clock) begin
    if (adv_we)    y_mem[walk_slot] <= adv_y;
    else if (push) y_mem[tail_q]    <= '0;
  end

  assign hit      = hit_q;
  assign miss     = miss_q;
  assign rd_y     = rd_y_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Testbench for note_lane_scheduler: directed scenarios plus random traffic,
// all checked every cycle against a queue-based model of the note lane.
module tb_note_lane_scheduler;

  localparam int DEPTH    = 8;
  localparam int SPEED    = 2;
  localparam int SCREEN_H = 480;
  localparam int HIT_LO   = 400;
  localparam int HIT_HI   = 440;
  localparam int Y_MAX    = 511;
`ifdef NOTE_LANE_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       spawn_valid = 1'b0;
  logic       strum = 1'b0;
  logic [2:0] rd_idx = '0;
  logic       spawn_ready, hit, miss, rd_valid, busy;
  logic [8:0] rd_y;
  logic [3:0] count;

  note_lane_scheduler dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .strum(strum),
    .hit(hit), .miss(miss), .rd_idx(rd_idx), .rd_y(rd_y),
    .rd_valid(rd_valid), .count(count), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Model: live notes oldest-first, plus the number of busy cycles left.
  int q[$];
  bit m_tick_pend = 1'b0;
  bit m_strum_pend = 1'b0;
  int busy_rem = 0;
  int hit_seen = 0;
  int miss_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check the combinational ready, clock, advance the model,
  // then check every registered output.
  task automatic step();
    bit e_ready, e_hit, e_miss, e_rd_valid, chk_rd_y, judge;
    int e_rd_y;
    e_ready = 1'b0;
    #1;
    if (!reset) begin
      e_ready = (busy_rem == 0) && (q.size() < DEPTH) && !frame_tick && !m_tick_pend;
      chk("spawn_ready", spawn_ready, e_ready);
    end
    e_rd_valid = int'(rd_idx) < q.size();
    chk_rd_y   = e_rd_valid && (busy_rem == 0);
    e_rd_y     = chk_rd_y ? q[rd_idx] : 0;
    @(posedge clock);
    e_hit = 1'b0;
    e_miss = 1'b0;
    if (reset) begin
      q.delete();
      m_tick_pend = 1'b0;
      m_strum_pend = 1'b0;
      busy_rem = 0;
      e_rd_valid = 1'b0;
      e_rd_y = 0;
      chk_rd_y = 1'b1;
    end else if (busy_rem == 0) begin
      if (frame_tick || m_tick_pend) begin
        m_tick_pend = 1'b0;
        busy_rem = q.size() + 2;
        if (HIT_EN && strum) m_strum_pend = 1'b1;
      end else begin
        judge = HIT_EN && (strum || m_strum_pend);
        m_strum_pend = 1'b0;
        if (judge) begin
          if (q.size() > 0 && q[0] >= HIT_LO && q[0] <= HIT_HI) begin
            void'(q.pop_front());
            e_hit = 1'b1;
          end else begin
            e_miss = 1'b1;
          end
        end
        if (spawn_valid && e_ready) q.push_back(0);
      end
    end else begin
      if (frame_tick) m_tick_pend = 1'b1;
      if (HIT_EN && strum) m_strum_pend = 1'b1;
      if (busy_rem == 1) begin
        foreach (q[i]) q[i] = (q[i] + SPEED > Y_MAX) ? Y_MAX : q[i] + SPEED;
        if (q.size() > 0 && q[0] >= SCREEN_H) begin
          void'(q.pop_front());
          e_miss = 1'b1;
        end
      end
      busy_rem--;
    end
    #1;
    chk("busy", busy, int'(busy_rem > 0));
    chk("count", count, q.size());
    chk("hit", hit, e_hit);
    chk("miss", miss, e_miss);
    chk("rd_valid", rd_valid, e_rd_valid);
    if (chk_rd_y) chk("rd_y", rd_y, e_rd_y);
    hit_seen  += int'(hit);
    miss_seen += int'(miss);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    spawn_valid = 1'b0;
    strum = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic spawn_n(input int n);
    spawn_valid = 1'b1;
    repeat (n) step();
    spawn_valid = 1'b0;
  endtask

  task automatic tick_wait();
    int guard;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    guard = 0;
    while (busy_rem > 0 && guard < 40) begin
      step();
      guard++;
    end
    if (busy_rem > 0) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout: busy_rem %0d required 0", busy_rem);
    end
  endtask

  initial begin
    int nb;

    // Reset values.
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_y", rd_y, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_miss", miss, 0);
    #1;
    chk("rst_ready", spawn_ready, 1);

    // Fill to DEPTH, then a refused ninth spawn.
    spawn_valid = 1'b1;
    repeat (8) step();
    chk("fill_count", count, 8);
    chk("fill_ready", spawn_ready, 0);
    step();
    spawn_valid = 1'b0;
    chk("fill_9th_count", count, 8);

    // Single note, single tick: busy for 3 cycles, then y=2.
    do_reset();
    spawn_n(1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    nb = int'(busy);
    for (int k = 0; k < 8; k++) begin
      step();
      nb += int'(busy);
    end
    chk("single_busy_cycles", nb, 3);
    rd_idx = 3'd0;
    step();
    chk("single_rd_y", rd_y, 2);
    chk("single_rd_valid", rd_valid, 1);

    // Walk the note to 478, then one more tick retires it.
    repeat (238) tick_wait();
    step();
    chk("offscreen_y478", rd_y, 478);
    miss_seen = 0;
    tick_wait();
    step();
    step();
    chk("offscreen_miss", miss_seen, 1);
    chk("offscreen_count", count, 0);

`ifdef NOTE_LANE_HIT_EN
    // In-window strum.
    do_reset();
    spawn_n(1);
    repeat (210) tick_wait();
    step();
    chk("win_y420", rd_y, 420);
    strum = 1'b1;
    step();
    strum = 1'b0;
    chk("win_hit", hit, 1);
    chk("win_count", count, 0);
    // Early strum at y=398.
    spawn_n(1);
    repeat (199) tick_wait();
    strum = 1'b1;
    step();
    strum = 1'b0;
    chk("early_miss", miss, 1);
    chk("early_hit", hit, 0);
    chk("early_count", count, 1);
    // Spawn and strum together with the head at y=410.
    do_reset();
    spawn_n(1);
    repeat (205) tick_wait();
    spawn_valid = 1'b1;
    strum = 1'b1;
    step();
    spawn_valid = 1'b0;
    strum = 1'b0;
    chk("both_hit", hit, 1);
    chk("both_count", count, 1);
    step();
    chk("both_new_y", rd_y, 0);
`endif

    // Tick and strum arriving mid-pass with four notes: two back-to-back passes.
    do_reset();
    spawn_n(4);
    frame_tick = 1'b1;
    step();
    nb = int'(busy);
    strum = 1'b1;
    step();
    nb += int'(busy);
    frame_tick = 1'b0;
    strum = 1'b0;
    for (int k = 0; k < 18; k++) begin
      step();
      nb += int'(busy);
    end
    chk("pend_busy_cycles", nb, 12);
    chk("pend_count", count, 4);

    // Reset in the middle of a walk.
    do_reset();
    spawn_n(3);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    do_reset();
    chk("midreset_count", count, 0);
    chk("midreset_busy", busy, 0);
    tick_wait();

    // Random traffic.
    for (int n = 0; n < 20000; n++) begin
      frame_tick  = ($urandom_range(0, 9) == 0);
      spawn_valid = ($urandom_range(0, 2) == 0);
      strum       = ($urandom_range(0, 11) == 0);
      rd_idx      = 3'($urandom_range(0, 7));
      step();
    end
    frame_tick = 1'b0;
    spawn_valid = 1'b0;
    strum = 1'b0;
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
